// File: rtl/uart_rx_frame_sipo_pkg.sv
// Shared definitions for the UART receive framing datapath: FSM states and parity-mode constants.
package uart_rx_frame_sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Error when the XOR over data and received parity bit disagrees with the selected mode.
  function automatic logic parity_mismatch(input logic xor_all, input logic mode);
    return xor_all != mode;
  endfunction

endpackage

// File: rtl/uart_rx_frame_sipo_out_buf.sv
// Holding register for completed words: valid/ready handshake plus overrun and parity flags.
module uart_rx_out_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] commit_data,
  input  logic                  commit_perr,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  overrun
);

  logic handshake;

  always_comb begin
    handshake = data_valid && data_ready;
  end

  // A commit wins over a handshake; overrun only flags a word that was never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      data_out   <= commit_data;
      data_valid <= 1'b1;
      parity_err <= commit_perr;
      overrun    <= data_valid && !handshake;
    end else if (handshake) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_frame_sipo.sv
// UART receive serial-in/parallel-out deserialiser: framing FSM, bit counter, shift register, parity.
module uart_rx_frame_sipo
  import uart_rx_frame_sipo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_data,
  input  logic                  shift_bit,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  rx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] sreg, sreg_nxt, shifted;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic                  commit, commit_perr;
  logic [DATA_WIDTH-1:0] commit_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    if (MSB_FIRST != 0) shifted = {sreg[DATA_WIDTH-2:0], rx_data};
    else                shifted = {rx_data, sreg[DATA_WIDTH-1:1]};
  end

  // frame_start outranks shift_bit in every state, so a coincident strobe is dropped.
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    commit      = 1'b0;
    commit_data = sreg;
    commit_perr = 1'b0;
    if (frame_start) begin
      state_nxt   = DATA;
      sreg_nxt    = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: ;
        DATA: begin
          if (shift_bit) begin
            sreg_nxt = shifted;
            if (bit_cnt == LAST_IDX) begin
              bit_cnt_nxt = FULL_CNT;
              if (PARITY_EN != 0) begin
                state_nxt = PARITY;
              end else begin
                state_nxt   = IDLE;
                commit      = 1'b1;
                commit_data = shifted;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (shift_bit) begin
            state_nxt   = IDLE;
            commit      = 1'b1;
            commit_data = sreg;
            commit_perr = parity_mismatch(^{sreg, rx_data}, PAR_MODE);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  uart_rx_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .commit     (commit),
    .commit_data(commit_data),
    .commit_perr(commit_perr),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

endmodule
